register_file_32x32: RTL and testbench

REGISTER_FILE_32X32 -- requirements
Module: register_file_32x32

---
 rtl/register_file_32x32_pkg.sv | 10 +
 rtl/register_file_32x32_decoder_5to32.sv | 13 +
 rtl/register_file_32x32.sv | 58 +++++
 tb/tb_register_file_32x32.sv | 125 ++++++++++++
 4 files changed

// File: rtl/register_file_32x32_pkg.sv
// register_file_32x32_pkg: shared sizes and types for the 32x32 register file
package register_file_32x32_pkg;
  localparam int REG_COUNT = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [7:0] WR_COUNT_MAX = 8'd255;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_ADDR_W-1:0] addr_t;
  typedef logic [REG_COUNT-1:0] sel_t;
endpackage

// File: rtl/register_file_32x32_decoder_5to32.sv
// decoder_5to32: one-hot decode of a 5-bit index, forced all-zero when en=0
//   x  - index to decode
//   en - enable; when low no select bit is set
//   y  - one-hot select, bit x set when en=1
module decoder_5to32
  import register_file_32x32_pkg::*;
(
  input  addr_t x,
  input  logic  en,
  output sel_t  y
);
  assign y = en ? sel_t'(1) << x : '0;
endmodule

// File: rtl/register_file_32x32.sv
// register_file_32x32: 32x32 register file, one write port, two combinational read ports
//   clk      - rising-edge clock for all state
//   reset    - synchronous active-high clear of registers and wr_count
//   we       - write enable
//   waddr    - write index (bit 0 is MSB)
//   wdata    - write data (bit 0 is MSB)
//   raddr_a  - read port A index, rdata_a its data
//   raddr_b  - read port B index, rdata_b its data
//   wr_count - committed writes since reset, saturating at 255
module register_file_32x32
  import register_file_32x32_pkg::*;
#(
  parameter int BYPASS = 0,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [0:4]  waddr,
  input  logic [0:31] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic [7:0]  wr_count
);
  data_t regs [REG_COUNT];
  sel_t  sel;
  sel_t  wsel;
  logic  zero_a;
  logic  zero_b;
  logic  byp_a;
  logic  byp_b;
  decoder_5to32 u_dec (
    .x (waddr),
    .en(we),
    .y (sel)
  );
  // Register 0 never takes a write when hardwired, so it also never counts.
  assign wsel = (ZERO_REG != 0) ? sel & ~sel_t'(1) : sel;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      wr_count <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) if (wsel[i]) regs[i] <= wdata;
      if (|wsel && wr_count != WR_COUNT_MAX) wr_count <= wr_count + 8'd1;
    end
  end
  // Forwarding only shows data that will actually commit: not under reset,
  // and never for a hardwired register 0 (zero_* wins below).
  assign zero_a = ZERO_REG != 0 && raddr_a == '0;
  assign zero_b = ZERO_REG != 0 && raddr_b == '0;
  assign byp_a = BYPASS != 0 && we && !reset && raddr_a == waddr;
  assign byp_b = BYPASS != 0 && we && !reset && raddr_b == waddr;
  assign rdata_a = zero_a ? '0 : byp_a ? wdata : regs[raddr_a];
  assign rdata_b = zero_b ? '0 : byp_b ? wdata : regs[raddr_b];
endmodule

// File: tb/tb_register_file_32x32.sv
// tb_register_file_32x32: scoreboard bench over three parameterisations of the register file
module tb_register_file_32x32;
  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  logic        clk = 0;
  logic        reset = 1;
  logic        we = 0;
  logic [0:4]  waddr = '0;
  logic [0:31] wdata = '0;
  logic [4:0]  raddr_a = '0;
  logic [4:0]  raddr_b = '0;
  logic [31:0] ra0, rb0, ra1, rb1, ra2, rb2;
  logic [7:0]  wc0, wc1, wc2;
  logic [31:0] m [32];
  int          cnt_z = 0;
  int          cnt_nz = 0;
  bit          known = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb [$];
  always #5 clk = ~clk;
  register_file_32x32 #(.BYPASS(0), .ZERO_REG(1)) d0 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra0), .rdata_b(rb0), .wr_count(wc0)
  );
  register_file_32x32 #(.BYPASS(1), .ZERO_REG(1)) d1 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra1), .rdata_b(rb1), .wr_count(wc1)
  );
  register_file_32x32 #(.BYPASS(0), .ZERO_REG(0)) d2 (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra2), .rdata_b(rb2), .wr_count(wc2)
  );
  function automatic logic [31:0] exp_rd(input bit byp, input bit zr, input logic [4:0] a);
    if (zr && a == 5'd0) return '0;
    if (byp && we && !reset && a == waddr) return wdata;
    return m[a];
  endfunction
  function automatic logic [31:0] act(input int sel);
    case (sel)
      0: return ra0;
      1: return rb0;
      2: return {24'd0, wc0};
      3: return ra1;
      4: return rb1;
      5: return {24'd0, wc1};
      6: return ra2;
      7: return rb2;
      default: return {24'd0, wc2};
    endcase
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic push_all(input string tag);
    for (int d = 0; d < 3; d++) begin
      sb.push_back('{{tag, "/rdata_a"}, d * 3, exp_rd(d == 1, d != 2, raddr_a)});
      sb.push_back('{{tag, "/rdata_b"}, d * 3 + 1, exp_rd(d == 1, d != 2, raddr_b)});
      sb.push_back('{{tag, "/wr_count"}, d * 3 + 2, 32'(d == 2 ? cnt_nz : cnt_z)});
    end
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s d%0d", e.tag, e.sel / 3), act(e.sel), e.exp);
    end
  endtask
  task automatic drive(input bit r, input bit w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a, input logic [4:0] b, input string tag);
    reset = r;
    we = w;
    waddr = wa;
    wdata = wd;
    raddr_a = a;
    raddr_b = b;
    #1;
    if (known) begin
      push_all(tag);
      drain();
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) m[i] = '0;
      cnt_z = 0;
      cnt_nz = 0;
      known = 1;
    end else if (w) begin
      m[wa] = wd;
      if (cnt_nz < 255) cnt_nz++;
      if (wa != 5'd0 && cnt_z < 255) cnt_z++;
    end
    @(negedge clk);
  endtask
  initial begin
    drive(1, 0, 0, 0, 0, 0, "rst");
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 5'(i * 9), 5'(31 - i * 5), "post_rst");
    drive(0, 1, 5, 32'hDEADBEEF, 5, 0, "w5");
    drive(0, 0, 0, 0, 5, 5, "r5");
    drive(0, 1, 0, 32'h12345678, 0, 0, "w0");
    drive(0, 0, 0, 0, 0, 0, "r0");
    drive(0, 1, 7, 32'h00000011, 3, 4, "w7");
    drive(0, 1, 7, 32'h00000022, 7, 7, "rdw7");
    drive(0, 0, 0, 0, 7, 7, "r7");
    drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, "byp0");
    drive(0, 0, 0, 0, 0, 5, "r0b");
    drive(1, 1, 31, 32'hA5A5A5A5, 31, 31, "rst_w31");
    drive(0, 0, 0, 0, 31, 5, "r31");
    for (int i = 0; i < 300; i++)
      drive(0, 1, 1, {32'(i)} * 32'h01010101 ^ 32'h5A000000, 1, 2, "sat");
    drive(0, 0, 1, 32'hDEADFACE, 1, 1, "hold");
    drive(0, 0, 1, 32'hDEADFACE, 1, 0, "hold2");
    for (int i = 1; i < 32; i++) drive(0, 1, 5'(i), 32'(i + 1), 5'(i), 0, "fill");
    for (int i = 0; i < 32; i++) drive(0, 0, 0, 0, 5'(i), 5'(31 - i), "sweep");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
